mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 256x8 program/data memory between two requesters: the CPU core (fetch, load, store) and a debug/loader port (program download and inspection from switches or a host).
- Holds the memory array internally.
- Round-robin arbitration with a req/gnt handshake, one-cycle registered read data, and a debug lock that stalls the CPU while a program is loaded.
- Sits between the CPU FSM and the memory.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- DEPTH, 256, number of words; must be <= 2**AW.

Ports:
- CLK_12MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request; held with cmd stable until cpu_gnt seen high.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  one-cycle pulse; CPU command accepted.
- cpu_rvalid  output  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  output  DW  read data for CPU.
- dbg_req  input  1  debug access request; same rules as cpu_req.
- dbg_we  input  1  debug write enable.
- dbg_addr  input  AW  debug address.
- dbg_wdata  input  DW  debug write data.
- dbg_lock  input  1  while high, CPU requests are never granted.
- dbg_gnt  output  1  one-cycle pulse; debug command accepted.
- dbg_rvalid  output  1  one-cycle pulse; dbg_rdata valid.
- dbg_rdata  output  DW  read data for debug.
- cpu_stall  output  1  high when cpu_req is high and cpu_gnt is low this cycle.
- busy  output  1  high while the FSM is in ACCESS.

Behaviour:
- Reset values: FSM = ARB; all gnt and rvalid outputs 0; rdata outputs 0; busy 0; last_winner = DBG, so the CPU wins the first tie.
  - Memory contents are not cleared by reset.
  - Reset wins over every other event at that edge.
- State ARB, edge with any eligible req:
  - Choose the winner and latch we/addr/wdata/winner id.
  - Set the winner's gnt <= 1 and go to ACCESS.
  - With no eligible req, stay in ARB and keep all gnt at 0.
- Eligibility:
  - dbg_req is always eligible.
  - cpu_req is eligible only if dbg_lock is 0 at the sampling edge.
- Tie (both eligible): grant the requester that is not last_winner, then update last_winner to the winner. A single eligible requester always wins and also updates last_winner.
- State ACCESS, one cycle:
  - Write: mem[addr] <= wdata.
  - Read: the winner's rdata <= mem[addr] and its rvalid <= 1.
  - gnt <= 0, busy = 1, return to ARB.
  - All req inputs are ignored in this state.
- Timing, with req sampled at edge k:
  - gnt is high in cycle k+1.
  - The write commits at edge k+1.
  - rdata/rvalid are high in cycle k+2.
  - The next request can be sampled at edge k+2.
  - Peak rate is 1 transaction per 2 cycles.
- Requester rule: a requester drops or changes req and cmd only after the edge at which it sees gnt = 1. A req still high at edge k+2 is treated as a new transaction.
- rdata holds its last value when rvalid is 0. rvalid is never high for writes.
- Out of range (addr >= DEPTH): writes are dropped; reads return 0 with rvalid still pulsed.
- Read-after-write: a read granted immediately after a write to the same address returns the new data.
- dbg_lock rising while the CPU is already in ACCESS does not abort that CPU transaction.
- Reset in ACCESS: a pending write is not performed and no rvalid is produced.
- cpu_stall is combinational: cpu_req & ~cpu_gnt.

Test Plan:
- Reset, then CPU writes 0x3C to addr 0x10, then CPU reads 0x10 -> cpu_gnt one cycle after each req; cpu_rdata = 0x3C with cpu_rvalid one cycle after gnt; dbg outputs stay 0.
- cpu_req and dbg_req held high together for 4 transactions (reads of 0x01/0x02) -> grants alternate CPU, DBG, CPU, DBG; no gnt in consecutive cycles.
- dbg_lock = 1 with cpu_req held for 10 cycles while debug writes 0xBF, 0xFE to addr 0, 1 -> cpu_gnt never asserts, cpu_stall high throughout; dbg_lock = 0 -> CPU granted on the next ARB edge and reads 0xBF from addr 0.
- DEPTH = 128: debug writes 0xAA to addr 0xF0, then reads it -> memory unchanged, dbg_rdata = 0x00, dbg_rvalid pulses.
- Reset asserted in the ACCESS cycle of a CPU write of 0x55 to 0x20 (previous content 0x11) -> after reset, a read of 0x20 returns 0x11; all gnt/rvalid are 0 in the cycle after reset.
- Debug write 0x07 to 0xFE, then a CPU read of 0xFE granted next -> cpu_rdata = 0x07; busy high exactly in the two ACCESS cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port DEPTH x DW memory between the CPU core and
// the debug/loader port. Round-robin arbitration with a req/gnt handshake,
// one-cycle registered read data, and a debug lock that holds off the CPU.
module mem_arbiter #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          CLK_12MHz,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          cpu_stall,
    output logic          busy
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic { ST_ARB = 1'b0, ST_ACCESS = 1'b1 } state_t;
    typedef enum logic { REQ_CPU = 1'b0, REQ_DBG = 1'b1 } req_id_t;

    state_t          state_q, state_d;
    req_id_t         last_q, last_d;
    req_id_t         win_q, win_d;
    req_id_t         arb_win;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            cpu_gnt_q, cpu_gnt_d;
    logic            dbg_gnt_q, dbg_gnt_d;
    logic            cpu_rvalid_q, cpu_rvalid_d;
    logic            dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic [DW-1:0]   mem [DEPTH];
    logic            cpu_elig;
    logic            in_range;
    logic [IW-1:0]   mem_idx;
    logic [DW-1:0]   rd_word;
    logic            mem_we;

    // The CPU is only a candidate while the debug port is not holding the lock.
    assign cpu_elig = cpu_req & ~dbg_lock;
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    assign mem_idx  = addr_q[IW-1:0];
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    // Next-state, arbitration and access-cycle decode.
    always_comb begin
        // NOTE: every signal gets its default here so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        last_d       = last_q;
        win_d        = win_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_we       = 1'b0;
        arb_win      = last_q;

        case (state_q)
            ST_ARB: begin
                if (cpu_elig || dbg_req) begin
                    // On a tie the requester that did not win last time goes first.
                    if (cpu_elig && dbg_req) begin
                        arb_win = (last_q == REQ_DBG) ? REQ_CPU : REQ_DBG;
                    end else begin
                        arb_win = cpu_elig ? REQ_CPU : REQ_DBG;
                    end
                    win_d     = arb_win;
                    last_d    = arb_win;
                    we_d      = (arb_win == REQ_CPU) ? cpu_we    : dbg_we;
                    addr_d    = (arb_win == REQ_CPU) ? cpu_addr  : dbg_addr;
                    wdata_d   = (arb_win == REQ_CPU) ? cpu_wdata : dbg_wdata;
                    cpu_gnt_d = (arb_win == REQ_CPU);
                    dbg_gnt_d = (arb_win == REQ_DBG);
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Requests are ignored here; the latched command is executed.
                state_d = ST_ARB;
                if (we_q) begin
                    // A reset landing on this edge cancels the write.
                    mem_we = in_range & ~reset;
                end else if (win_q == REQ_CPU) begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = rd_word;
                end else begin
                    dbg_rvalid_d = 1'b1;
                    dbg_rdata_d  = rd_word;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State and registered outputs; reset has priority over everything.
    always_ff @(posedge CLK_12MHz) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q      <= ST_ARB;
            last_q       <= REQ_DBG;
            win_q        <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            win_q        <= win_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Memory write port.
    always_ff @(posedge CLK_12MHz) begin
        // NOTE: the array has no reset; program contents must survive a reset.
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign busy       = (state_q == ST_ACCESS);
    assign cpu_stall  = cpu_req & ~cpu_gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a full-depth instance and a DEPTH=128 instance
// share one stimulus stream; a transaction-level reference model predicts
// grants, read data and memory contents for both.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

    logic       b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid, b_cpu_stall, b_busy;
    logic [7:0] b_cpu_rdata, b_dbg_rdata;
    logic       s_cpu_gnt, s_cpu_rvalid, s_dbg_gnt, s_dbg_rvalid, s_cpu_stall, s_busy;
    logic [7:0] s_cpu_rdata, s_dbg_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(8), .DEPTH(256)) dut (
        .CLK_12MHz(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
        .cpu_stall(b_cpu_stall), .busy(b_busy)
    );

    mem_arbiter #(.AW(8), .DW(8), .DEPTH(128)) dut_small (
        .CLK_12MHz(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
        .cpu_stall(s_cpu_stall), .busy(s_busy)
    );

    // ---------------- reference model ----------------
    logic [7:0] ref_big   [256];
    logic [7:0] ref_small [128];
    bit         txn_open;     // a granted transaction executes at the next edge
    bit         m_win_dbg, m_last_dbg, m_we;
    logic [7:0] m_addr, m_wdata;
    bit         e_cgnt, e_dgnt, e_crv, e_drv, e_busy;
    logic [7:0] e_crd, e_drd, e_crd_s, e_drd_s;

    // Predicts the effect of the coming rising edge, then advances to the
    // following falling edge where outputs are observed.
    task automatic tick();
        bit c_ok;
        logic [7:0] rd_b, rd_s;
        if (reset) begin
            txn_open = 0; m_last_dbg = 1;
            e_cgnt = 0; e_dgnt = 0; e_crv = 0; e_drv = 0; e_busy = 0;
            e_crd = 0; e_drd = 0; e_crd_s = 0; e_drd_s = 0;
        end else if (txn_open) begin
            txn_open = 0;
            e_cgnt = 0; e_dgnt = 0; e_busy = 0; e_crv = 0; e_drv = 0;
            if (m_we) begin
                ref_big[m_addr] = m_wdata;
                if (m_addr < 8'd128) ref_small[m_addr[6:0]] = m_wdata;
            end else begin
                rd_b = ref_big[m_addr];
                rd_s = (m_addr < 8'd128) ? ref_small[m_addr[6:0]] : 8'h00;
                if (m_win_dbg) begin e_drv = 1; e_drd = rd_b; e_drd_s = rd_s; end
                else           begin e_crv = 1; e_crd = rd_b; e_crd_s = rd_s; end
            end
        end else begin
            e_crv = 0; e_drv = 0;
            c_ok = cpu_req && !dbg_lock;
            if (c_ok || dbg_req) begin
                m_win_dbg  = (c_ok && dbg_req) ? !m_last_dbg : dbg_req;
                m_last_dbg = m_win_dbg;
                m_we    = m_win_dbg ? dbg_we    : cpu_we;
                m_addr  = m_win_dbg ? dbg_addr  : cpu_addr;
                m_wdata = m_win_dbg ? dbg_wdata : cpu_wdata;
                e_cgnt = !m_win_dbg; e_dgnt = m_win_dbg; e_busy = 1; txn_open = 1;
            end else begin
                e_cgnt = 0; e_dgnt = 0; e_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        cpu_we = 0; dbg_we = 0; cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
        tick(); tick();
        reset = 0;
        checks++; if ({b_cpu_gnt, b_dbg_gnt, b_cpu_rvalid, b_dbg_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt_rvalid: got %b exp 0000", {b_cpu_gnt, b_dbg_gnt, b_cpu_rvalid, b_dbg_rvalid}); end
        checks++; if ({b_cpu_rdata, b_dbg_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h exp 0000", {b_cpu_rdata, b_dbg_rdata}); end
        checks++; if (b_busy !== 1'b0 || b_cpu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_busy_stall: got %b%b exp 00", b_busy, b_cpu_stall); end
        checks++; if ({s_cpu_gnt, s_dbg_gnt, s_cpu_rvalid, s_dbg_rvalid, s_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_small: got %b exp 00000", {s_cpu_gnt, s_dbg_gnt, s_cpu_rvalid, s_dbg_rvalid, s_busy}); end
        tick();
        checks++; if ({b_cpu_gnt, b_dbg_gnt, b_busy} !== 3'b000) begin
            errors++; $display("FAIL idle_no_gnt: got %b exp 000", {b_cpu_gnt, b_dbg_gnt, b_busy}); end
    endtask

    task automatic test_cpu_basic();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h3C;
        tick();
        checks++; if (b_cpu_gnt !== 1'b1 || b_dbg_gnt !== 1'b0) begin
            errors++; $display("FAIL cpu_wr_gnt: got cpu=%b dbg=%b exp 1 0", b_cpu_gnt, b_dbg_gnt); end
        checks++; if (b_busy !== 1'b1 || b_cpu_stall !== 1'b0) begin
            errors++; $display("FAIL cpu_wr_busy_stall: got %b%b exp 10", b_busy, b_cpu_stall); end
        cpu_req = 0;
        tick();
        checks++; if (b_cpu_gnt !== 1'b0 || b_cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL cpu_wr_no_rvalid: got gnt=%b rvalid=%b exp 0 0", b_cpu_gnt, b_cpu_rvalid); end
        cpu_req = 1; cpu_we = 0;
        tick();
        checks++; if (b_cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL cpu_rd_gnt: got %b exp 1", b_cpu_gnt); end
        cpu_req = 0;
        tick();
        checks++; if (b_cpu_rvalid !== 1'b1 || b_cpu_rdata !== 8'h3C) begin
            errors++; $display("FAIL cpu_rd_data: got rvalid=%b data=%h exp 1 3c", b_cpu_rvalid, b_cpu_rdata); end
        checks++; if ({b_dbg_gnt, b_dbg_rvalid} !== 2'b00 || b_dbg_rdata !== 8'h00) begin
            errors++; $display("FAIL cpu_basic_dbg_quiet: got %b %h exp 00 00", {b_dbg_gnt, b_dbg_rvalid}, b_dbg_rdata); end
        tick();
        checks++; if (b_cpu_rvalid !== 1'b0 || b_cpu_rdata !== 8'h3C) begin
            errors++; $display("FAIL cpu_rdata_hold: got rvalid=%b data=%h exp 0 3c", b_cpu_rvalid, b_cpu_rdata); end
    endtask

    // Program download through the debug port; fills every address.
    task automatic test_load();
        for (int a = 0; a < 256; a++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = a[7:0]; dbg_wdata = 8'($urandom);
            tick();
            checks++; if (b_dbg_gnt !== 1'b1 || b_cpu_gnt !== 1'b0) begin
                errors++; $display("FAIL load_gnt a=%0d: got dbg=%b cpu=%b exp 1 0", a, b_dbg_gnt, b_cpu_gnt); end
            dbg_req = 0;
            tick();
            checks++; if (b_dbg_rvalid !== 1'b0 || b_busy !== 1'b0) begin
                errors++; $display("FAIL load_done a=%0d: got rvalid=%b busy=%b exp 0 0", a, b_dbg_rvalid, b_busy); end
        end
    endtask

    task automatic test_round_robin();
        bit exp_dbg;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h02;
        for (int t = 0; t < 4; t++) begin
            exp_dbg = (t % 2) == 1;
            tick();
            checks++; if (b_cpu_gnt !== !exp_dbg || b_dbg_gnt !== exp_dbg) begin
                errors++; $display("FAIL rr_gnt t=%0d: got cpu=%b dbg=%b exp %b %b", t, b_cpu_gnt, b_dbg_gnt, !exp_dbg, exp_dbg); end
            tick();
            checks++; if ({b_cpu_gnt, b_dbg_gnt} !== 2'b00) begin
                errors++; $display("FAIL rr_gap t=%0d: got %b exp 00", t, {b_cpu_gnt, b_dbg_gnt}); end
            checks++; if (b_cpu_rvalid !== !exp_dbg || b_dbg_rvalid !== exp_dbg) begin
                errors++; $display("FAIL rr_rvalid t=%0d: got cpu=%b dbg=%b exp %b %b", t, b_cpu_rvalid, b_dbg_rvalid, !exp_dbg, exp_dbg); end
            checks++; if (exp_dbg ? (b_dbg_rdata !== ref_big[2]) : (b_cpu_rdata !== ref_big[1])) begin
                errors++; $display("FAIL rr_rdata t=%0d: got cpu=%h dbg=%h exp %h", t, b_cpu_rdata, b_dbg_rdata, exp_dbg ? ref_big[2] : ref_big[1]); end
        end
        cpu_req = 0; dbg_req = 0;
    endtask

    task automatic test_lock();
        dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
        for (int c = 0; c < 10; c++) begin
            dbg_req = (c == 0 || c == 2); dbg_we = 1;
            dbg_addr  = (c < 2) ? 8'h00 : 8'h01;
            dbg_wdata = (c < 2) ? 8'hBF : 8'hFE;
            tick();
            checks++; if (b_cpu_gnt !== 1'b0 || b_cpu_stall !== 1'b1) begin
                errors++; $display("FAIL lock_hold c=%0d: got gnt=%b stall=%b exp 0 1", c, b_cpu_gnt, b_cpu_stall); end
            if (c == 0 || c == 2) begin
                checks++; if (b_dbg_gnt !== 1'b1) begin
                    errors++; $display("FAIL lock_dbg_gnt c=%0d: got %b exp 1", c, b_dbg_gnt); end
            end
        end
        dbg_req = 0; dbg_lock = 0;
        tick();
        checks++; if (b_cpu_gnt !== 1'b1 || b_cpu_stall !== 1'b0) begin
            errors++; $display("FAIL unlock_gnt: got gnt=%b stall=%b exp 1 0", b_cpu_gnt, b_cpu_stall); end
        cpu_req = 0;
        tick();
        checks++; if (b_cpu_rvalid !== 1'b1 || b_cpu_rdata !== 8'hBF) begin
            errors++; $display("FAIL unlock_rdata: got rvalid=%b data=%h exp 1 bf", b_cpu_rvalid, b_cpu_rdata); end
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h01;
        tick();
        dbg_req = 0;
        tick();
        checks++; if (b_dbg_rvalid !== 1'b1 || b_dbg_rdata !== 8'hFE) begin
            errors++; $display("FAIL lock_dbg_wr1: got rvalid=%b data=%h exp 1 fe", b_dbg_rvalid, b_dbg_rdata); end
    endtask

    task automatic test_out_of_range();
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'hF0; dbg_wdata = 8'hAA;
        tick(); dbg_req = 0; tick();
        dbg_req = 1; dbg_we = 0;
        tick(); dbg_req = 0; tick();
        checks++; if (s_dbg_rvalid !== 1'b1 || s_dbg_rdata !== 8'h00) begin
            errors++; $display("FAIL oor_small_read: got rvalid=%b data=%h exp 1 00", s_dbg_rvalid, s_dbg_rdata); end
        checks++; if (b_dbg_rvalid !== 1'b1 || b_dbg_rdata !== 8'hAA) begin
            errors++; $display("FAIL oor_big_read: got rvalid=%b data=%h exp 1 aa", b_dbg_rvalid, b_dbg_rdata); end
        dbg_req = 1; dbg_addr = 8'h70;
        tick(); dbg_req = 0; tick();
        checks++; if (s_dbg_rvalid !== 1'b1 || s_dbg_rdata !== ref_small[7'h70]) begin
            errors++; $display("FAIL oor_no_alias: got rvalid=%b data=%h exp 1 %h", s_dbg_rvalid, s_dbg_rdata, ref_small[7'h70]); end
    endtask

    task automatic test_reset_in_access();
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 8'h11;
        tick(); dbg_req = 0; tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h55;
        tick();
        checks++; if (b_cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_acc_gnt: got %b exp 1", b_cpu_gnt); end
        cpu_req = 0; reset = 1;
        tick();
        reset = 0;
        checks++; if ({b_cpu_gnt, b_dbg_gnt, b_cpu_rvalid, b_dbg_rvalid, b_busy} !== 5'b0) begin
            errors++; $display("FAIL rst_acc_outputs: got %b exp 00000", {b_cpu_gnt, b_dbg_gnt, b_cpu_rvalid, b_dbg_rvalid, b_busy}); end
        cpu_req = 1; cpu_we = 0;
        tick(); cpu_req = 0; tick();
        checks++; if (b_cpu_rvalid !== 1'b1 || b_cpu_rdata !== 8'h11) begin
            errors++; $display("FAIL rst_acc_no_write: got rvalid=%b data=%h exp 1 11", b_cpu_rvalid, b_cpu_rdata); end
    endtask

    task automatic test_read_after_write();
        logic [3:0] busy_seen;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'hFE; dbg_wdata = 8'h07;
        tick(); busy_seen[3] = b_busy;
        checks++; if (b_dbg_gnt !== 1'b1) begin
            errors++; $display("FAIL raw_dbg_gnt: got %b exp 1", b_dbg_gnt); end
        dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'hFE;
        tick(); busy_seen[2] = b_busy;
        tick(); busy_seen[1] = b_busy;
        checks++; if (b_cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL raw_cpu_gnt: got %b exp 1", b_cpu_gnt); end
        cpu_req = 0;
        tick(); busy_seen[0] = b_busy;
        checks++; if (b_cpu_rvalid !== 1'b1 || b_cpu_rdata !== 8'h07) begin
            errors++; $display("FAIL raw_rdata: got rvalid=%b data=%h exp 1 07", b_cpu_rvalid, b_cpu_rdata); end
        checks++; if (busy_seen !== 4'b1010) begin
            errors++; $display("FAIL raw_busy: got %b exp 1010", busy_seen); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!cpu_req || e_cgnt) begin
                cpu_req = ($urandom_range(0, 2) != 0); cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
            end
            if (!dbg_req || e_dgnt) begin
                dbg_req = ($urandom_range(0, 2) != 0); dbg_we = $urandom_range(0, 1) == 1;
                dbg_addr = 8'($urandom); dbg_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = !dbg_lock;
            tick();
            checks++; if (b_cpu_gnt !== e_cgnt || b_dbg_gnt !== e_dgnt) begin
                errors++; $display("FAIL rand_gnt c=%0d: got cpu=%b dbg=%b exp %b %b", c, b_cpu_gnt, b_dbg_gnt, e_cgnt, e_dgnt); end
            checks++; if (b_cpu_rvalid !== e_crv || b_dbg_rvalid !== e_drv) begin
                errors++; $display("FAIL rand_rvalid c=%0d: got cpu=%b dbg=%b exp %b %b", c, b_cpu_rvalid, b_dbg_rvalid, e_crv, e_drv); end
            checks++; if (b_cpu_rdata !== e_crd || b_dbg_rdata !== e_drd) begin
                errors++; $display("FAIL rand_rdata c=%0d: got cpu=%h dbg=%h exp %h %h", c, b_cpu_rdata, b_dbg_rdata, e_crd, e_drd); end
            checks++; if (s_cpu_rdata !== e_crd_s || s_dbg_rdata !== e_drd_s || s_dbg_rvalid !== e_drv) begin
                errors++; $display("FAIL rand_small c=%0d: got cpu=%h dbg=%h rv=%b exp %h %h %b", c, s_cpu_rdata, s_dbg_rdata, s_dbg_rvalid, e_crd_s, e_drd_s, e_drv); end
            checks++; if (b_busy !== e_busy || b_cpu_stall !== (cpu_req & !e_cgnt)) begin
                errors++; $display("FAIL rand_busy_stall c=%0d: got %b%b exp %b%b", c, b_busy, b_cpu_stall, e_busy, cpu_req & !e_cgnt); end
        end
        cpu_req = 0; dbg_req = 0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_cpu_basic();
        test_load();
        test_round_robin();
        test_lock();
        test_out_of_range();
        test_reset_in_access();
        test_read_after_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
